// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Single-outstanding-request fetch unit. It requests one instruction word at
//   a time from instruction memory, buffers the returned word and pushes it into
//   the instruction queue. It then advances the PC by 4 and issues the next
//   request. A flush redirects the PC. A request that has already been issued
//   cannot be cancelled, so it is drained and its data is discarded.
//
//   Optional feature: define FETCH_STALL_CNT_EN to add the stall_cnt output.
//   This is a saturating count of cycles spent holding an instruction while the
//   queue is full.
//
// Ports
//   clk            in   clock; all state updates on its rising edge
//   reset_n        in   asynchronous active-low reset
//   imem_read      out  memory read request (high in REQ and DRAIN)
//   imem_address   out  request address, stable until imem_resp
//   imem_rdata     in   returned instruction, valid with imem_resp
//   imem_resp      in   one-cycle response pulse
//   issue_q_full_n in   instruction queue can accept an entry this cycle
//   iq_load        out  push iq_inst/iq_pc into the queue this cycle
//   iq_inst        out  instruction word being pushed
//   iq_pc          out  PC of the instruction being pushed
//   flush          in   redirect pulse from the ROB
//   flush_pc       in   redirect target, valid with flush
//   stall_cnt      out  queue-full stall counter (FETCH_STALL_CNT_EN only)
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        issue_q_full_n,
  output logic        iq_load,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] inst_buf, inst_buf_nxt;
  logic [31:0] inst_pc, inst_pc_nxt;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      inst_buf <= 32'd0;
      inst_pc  <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
      inst_buf <= inst_buf_nxt;
      inst_pc  <= inst_pc_nxt;
    end
  end

  // Next-state, datapath update and queue push decision.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    inst_buf_nxt = inst_buf;
    inst_pc_nxt  = inst_pc;
    iq_load      = 1'b0;

    // A flush always retargets the PC, whatever state the fetch is in.
    if (flush) begin
      pc_nxt = flush_pc;
    end else begin
      pc_nxt = pc;
    end

    case (state)
      IDLE: begin
        if (!flush) begin
          req_addr_nxt = pc;
          state_nxt    = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (flush) begin
          // If the response has not arrived, it is still owed. Wait for it in DRAIN.
          state_nxt = imem_resp ? IDLE : DRAIN;
        end else if (imem_resp) begin
          inst_buf_nxt = imem_rdata;
          inst_pc_nxt  = req_addr;
          state_nxt    = ISSUE;
        end else begin
          state_nxt = REQ;
        end
      end
      ISSUE: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (issue_q_full_n) begin
          iq_load      = 1'b1;
          pc_nxt       = pc + 32'd4;
          req_addr_nxt = pc + 32'd4;
          state_nxt    = REQ;
        end else begin
          state_nxt = ISSUE;
        end
      end
      DRAIN: begin
        if (imem_resp) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign imem_read    = (state == REQ) || (state == DRAIN);
  assign imem_address = req_addr;
  assign iq_inst      = inst_buf;
  assign iq_pc        = inst_pc;

`ifdef FETCH_STALL_CNT_EN
  // Saturating count of cycles an instruction is held because the queue is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
    end else if ((state == ISSUE) && !issue_q_full_n && !flush &&
                 (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h4000_0060;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        issue_q_full_n;
  logic        iq_load;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        flush;
  logic [31:0] flush_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .issue_q_full_n(issue_q_full_n),
    .iq_load(iq_load), .iq_inst(iq_inst), .iq_pc(iq_pc),
    .flush(flush), .flush_pc(flush_pc)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc;
  // Reference model: next PC expected to be pushed, and the memory's latency state.
  logic [31:0] exp_pc;
  int mem_age, mem_lat, fixed_lat, spur_pct;
  bit lat_rand;
  logic prev_pend;
  logic [31:0] prev_addr;
  logic [31:0] log_pc[$];
  int log_cyc[$];

  // Memory contents: any fixed, address-dependent function will do.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic pick_lat();
    mem_lat = lat_rand ? int'($urandom_range(3, 1)) : fixed_lat;
  endtask

  // Hold reset, check the reset outputs, then release on a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    imem_resp = 1'b0; imem_rdata = 32'd0; issue_q_full_n = 1'b1;
    flush = 1'b0; flush_pc = 32'd0;
    mem_age = 0; prev_pend = 1'b0; exp_pc = RESET_PC; cyc = 0;
    pick_lat();
    @(negedge clk); @(negedge clk); #1;
    check_eq("rst_imem_read", {31'd0, imem_read}, 32'd0);
    check_eq("rst_iq_load", {31'd0, iq_load}, 32'd0);
    check_eq("rst_imem_address", imem_address, RESET_PC);
    check_eq("rst_iq_inst", iq_inst, 32'd0);
    check_eq("rst_iq_pc", iq_pc, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    check_eq("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    log_pc.delete(); log_cyc.delete();
  endtask

  // One clock cycle: drive inputs and memory at the falling edge, then check
  // the transaction-level outputs against the model.
  task automatic cycle(input logic fn, input logic fl, input logic [31:0] fpc);
    issue_q_full_n = fn; flush = fl; flush_pc = fpc;
    if (imem_read) begin
      mem_age++;
      if (mem_age >= mem_lat) begin
        imem_resp = 1'b1; imem_rdata = memfn(imem_address);
        mem_age = 0; pick_lat();
      end else begin
        imem_resp = 1'b0; imem_rdata = $urandom;
      end
    end else begin
      mem_age = 0;
      imem_resp = (int'($urandom_range(99, 0)) < spur_pct);
      imem_rdata = $urandom;
    end
    #1;
    cyc++;
    if (prev_pend) begin
      check_eq("read_hold", {31'd0, imem_read}, 32'd1);
      check_eq("addr_hold", imem_address, prev_addr);
    end
    if (fl || !fn) check_eq("no_push", {31'd0, iq_load}, 32'd0);
    if (iq_load) begin
      check_eq("push_pc", iq_pc, exp_pc);
      check_eq("push_inst", iq_inst, memfn(exp_pc));
      log_pc.push_back(iq_pc); log_cyc.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
    end
    if (fl) exp_pc = fpc;
    prev_pend = imem_read && !imem_resp;
    prev_addr = imem_address;
    @(posedge clk); @(negedge clk);
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (log_pc.size() > i) ? log_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] cyc_at(input int i);
    return (log_cyc.size() > i) ? 32'(log_cyc[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, fpc;
    lat_rand = 1'b0; fixed_lat = 1; spur_pct = 0;

    // Throughput with 1-cycle memory: pushes on cycles 3, 5 and 7.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'd0);
    check_eq("thr_pc0", log_at(0), 32'h4000_0060);
    check_eq("thr_pc1", log_at(1), 32'h4000_0064);
    check_eq("thr_pc2", log_at(2), 32'h4000_0068);
    check_eq("thr_cyc0", cyc_at(0), 32'd3);
    check_eq("thr_cyc1", cyc_at(1), 32'd5);
    check_eq("thr_cyc2", cyc_at(2), 32'd7);

    // Queue full for 5 cycles while an instruction is held.
    do_reset();
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      check_eq("stall_read", {31'd0, imem_read}, 32'd0);
      check_eq("stall_inst", iq_inst, memfn(RESET_PC));
    end
    cycle(1'b1, 1'b0, 32'd0);
    check_eq("stall_push_cyc", cyc_at(0), 32'd8);
`ifdef FETCH_STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt, 32'd5);
`endif

    // Flush while the request is pending; response arrives 3 cycles later.
    fixed_lat = 4;
    do_reset();
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h0000_1000);
    for (int i = 0; i < 3; i++) begin
      check_eq("drain_read", {31'd0, imem_read}, 32'd1);
      check_eq("drain_addr", imem_address, RESET_PC);
      cycle(1'b1, 1'b0, 32'd0);
    end
    check_eq("drain_done", {31'd0, imem_read}, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    check_eq("redir_addr", imem_address, 32'h0000_1000);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'd0);
    check_eq("redir_push", log_at(0), 32'h0000_1000);

    // Flush coincident with the response.
    fixed_lat = 1;
    do_reset();
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h0000_2340);
    check_eq("coinc_read", {31'd0, imem_read}, 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'd0);
    check_eq("coinc_push", log_at(0), 32'h0000_2340);

    // PC wrap at the top of the address space.
    do_reset();
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'd0);
    check_eq("wrap_pc0", log_at(0), 32'hFFFF_FFFC);
    check_eq("wrap_pc1", log_at(1), 32'h0000_0000);

    // Asynchronous reset in the middle of a request, away from a clock edge.
    fixed_lat = 3;
    do_reset();
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_read", {31'd0, imem_read}, 32'd0);
    check_eq("async_load", {31'd0, iq_load}, 32'd0);
    check_eq("async_addr", imem_address, RESET_PC);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'd0);
    check_eq("async_push", log_at(0), RESET_PC);

    // Randomized traffic: latency, back-pressure, flushes, stray responses.
    lat_rand = 1'b1; spur_pct = 10;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      fpc = (r[0] == 1'b1) ? {r[31:2], 2'b00} : (32'hFFFF_FFF0 + {28'd0, r[5:2], 2'b00});
      cycle(($urandom_range(3, 0) != 0), (int'($urandom_range(99, 0)) < 3), fpc);
    end
    check_eq("rand_progress", {31'd0, (log_pc.size() >= 100)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h4000_0060, PC loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 imem_read  out  1  instruction memory read request.
REQ-005 imem_address  out  32  request address.
REQ-006 imem_rdata  in  32  returned instruction; valid only with imem_resp.
REQ-007 imem_resp  in  1  one-cycle response pulse completing the outstanding request.
REQ-008 issue_q_full_n  in  1  instruction queue can accept an entry this cycle.
REQ-009 iq_load  out  1  push one entry into the instruction queue this cycle.
REQ-010 iq_inst  out  32  instruction word pushed.
REQ-011 iq_pc  out  32  PC of pushed instruction.
REQ-012 flush  in  1  redirect from ROB (mispredict/exception); one-cycle pulse.
REQ-013 flush_pc  in  32  redirect target; valid with flush.
REQ-014 stall_cnt  out  32  queue-full stall counter; present only with FETCH_STALL_CNT_EN.

Function
REQ-015 States: IDLE, REQ, ISSUE, DRAIN; state, pc, req_addr, inst_buf, inst_pc are registers.
REQ-016 imem_read = 1 exactly in REQ and DRAIN; imem_address = req_addr; held stable until imem_resp.
REQ-017 IDLE, no flush: req_addr <= pc, go REQ.
REQ-018 REQ, imem_resp, no flush: inst_buf <= imem_rdata, inst_pc <= req_addr, go ISSUE.
REQ-019 REQ, no imem_resp, no flush: stay REQ.
REQ-020 ISSUE: iq_load = issue_q_full_n & ~flush (combinational); iq_inst = inst_buf, iq_pc = inst_pc.
REQ-021 ISSUE with push: pc <= pc+4, req_addr <= pc+4, go REQ; without push (queue full), stay ISSUE holding buffer.
REQ-022 pc arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-023 Flush has priority over all other events: pc <= flush_pc, iq_load = 0 that cycle.
REQ-024 Flush in IDLE or ISSUE: go IDLE; buffered instruction discarded.
REQ-025 Flush in REQ without imem_resp: go DRAIN (request cannot be cancelled).
REQ-026 Flush in REQ coincident with imem_resp: data discarded, go IDLE.
REQ-027 DRAIN: keep req_addr; on imem_resp discard data, go IDLE; flush in DRAIN updates pc, stays DRAIN (or IDLE if imem_resp same cycle).
REQ-028 Throughput: one instruction every 2 cycles with 1-cycle memory and non-full queue; first push no earlier than cycle 3 after reset release.
REQ-029 Exactly one outstanding request at any time; imem_resp outside REQ/DRAIN ignored.

Reset
REQ-030 reset_n low asynchronously forces: state IDLE, pc = RESET_PC, req_addr = RESET_PC, inst_buf = 0, inst_pc = 0, stall_cnt = 0.
REQ-031 During reset outputs: imem_read 0, iq_load 0, imem_address RESET_PC, iq_inst 0, iq_pc 0.
REQ-032 Reset mid-request abandons the request; memory is reset by the same reset_n.

Configuration
REQ-033 Macro FETCH_STALL_CNT_EN defined: stall_cnt increments each cycle in ISSUE with issue_q_full_n = 0 and no flush, saturates at 32'hFFFF_FFFF.
REQ-034 Macro undefined: stall_cnt port and counter absent; all other behaviour identical.

Verification
REQ-035 Reset release, 1-cycle memory, queue never full -> pushes with iq_pc 4000_0060, 4000_0064, 4000_0068 every 2 cycles.
REQ-036 issue_q_full_n low 5 cycles while in ISSUE -> iq_load 0, imem_read 0, iq_inst stable; push on cycle issue_q_full_n rises; stall_cnt = 5 if macro defined.
REQ-037 flush to 32'h0000_1000 while REQ pending, response 3 cycles later -> imem_address holds old address, response data not pushed, next request address 32'h0000_1000.
REQ-038 flush coincident with imem_resp and issue_q_full_n high -> no iq_load; next push iq_pc = flush_pc.
REQ-039 flush_pc 32'hFFFF_FFFC -> pushes iq_pc FFFF_FFFC then 0000_0000.
REQ-040 reset_n asserted mid-REQ, off clock edge -> imem_read and iq_load drop immediately, pc = RESET_PC.
